retire_trace_tx: RTL and testbench

RETIRE_TRACE_TX -- requirements
Module: retire_trace_tx

---
 rtl/retire_trace_if.sv | 20 ++
 rtl/retire_trace_tx.sv | 181 ++++++++++++++++++
 tb/tb_retire_trace_tx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/retire_trace_if.sv
// Trace record channel for retire_trace_tx: valid/ready handshake carrying one
// record per transfer. The producer uses the master modport.
interface retire_trace_if;
  logic        tr_valid;
  logic        tr_ready;
  logic [1:0]  tr_kind;
  logic [15:0] tr_a;
  logic [15:0] tr_b;
  logic [15:0] tr_cycle;

  modport master (
    output tr_valid, tr_kind, tr_a, tr_b, tr_cycle,
    input  tr_ready
  );

  modport slave (
    input  tr_valid, tr_kind, tr_a, tr_b, tr_cycle,
    output tr_ready
  );
endinterface

// File: rtl/retire_trace_tx.sv
// Retire trace transmitter: turns retire events into REG/LOAD/STORE/HALT records in a FWFT FIFO.
// Optional macro TRACE_CYCLE_STAMP_EN adds a 16-bit cycle stamp to every record.
module retire_trace_tx #(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reg_wrt,
  input  logic [2:0]    wr_reg,
  input  logic [15:0]   wr_data,
  input  logic          mem_rd,
  input  logic          mem_wrt,
  input  logic [15:0]   mem_addr,
  input  logic [15:0]   mem_data_in,
  input  logic [15:0]   mem_data_out,
  input  logic          halt,
  retire_trace_if.master tr,
  output logic [7:0]    drop_cnt,
  output logic          overflow,
  output logic          proto_err,
  output logic          done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("retire_trace_tx: DEPTH must be a power of two and at least 4");
  end

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  typedef enum logic [1:0] {
    K_REG   = 2'b00,
    K_LOAD  = 2'b01,
    K_STORE = 2'b10,
    K_HALT  = 2'b11
  } kind_t;

  typedef struct packed {
    kind_t       kind;
    logic [15:0] a;
    logic [15:0] b;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [15:0] stamp;
`endif
  } rec_t;

  state_t        state_q, state_d;
  rec_t          mem [DEPTH];
  rec_t          slot [3];
  rec_t          head;
  logic [PW-1:0] wptr_q, rptr_q, count;
  logic [PW:0]   free_slots;
  logic [1:0]    need;
  logic [15:0]   icnt_q, icnt_inc;
  logic          run, empty, pop, push, drop, counts_instr;

`ifdef TRACE_CYCLE_STAMP_EN
  logic [15:0]   cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_q + 16'd1;
  end
`endif

  // Occupancy, handshake and this cycle's record set, packed into slots in emit order.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    for (int i = 0; i < 3; i++) slot[i] = '0;
    need         = '0;
    run          = (state_q == RUN);
    count        = wptr_q - rptr_q;
    empty        = (count == '0);
    pop          = !empty && tr.tr_ready;
    free_slots   = DEPTH_W - {1'b0, count} + {{PW{1'b0}}, pop};
    icnt_inc     = icnt_q + 16'd1;
    counts_instr = run && (reg_wrt || mem_wrt || halt);

    if (run) begin
      if (reg_wrt) begin
        slot[need].kind = K_REG;
        slot[need].a    = {13'b0, wr_reg};
        slot[need].b    = wr_data;
        need            = need + 2'd1;
      end
      if (mem_wrt) begin
        slot[need].kind = K_STORE;
        slot[need].a    = mem_addr;
        slot[need].b    = mem_data_in;
        need            = need + 2'd1;
      end else if (mem_rd) begin
        slot[need].kind = K_LOAD;
        slot[need].a    = mem_addr;
        slot[need].b    = mem_data_out;
        need            = need + 2'd1;
      end
      if (halt) begin
        slot[need].kind = K_HALT;
        slot[need].a    = '0;
        slot[need].b    = icnt_inc;
        need            = need + 2'd1;
      end
    end

`ifdef TRACE_CYCLE_STAMP_EN
    for (int i = 0; i < 3; i++) slot[i].stamp = cyc_q;
`endif

    // A cycle's records go in together or not at all.
    push = (need != '0) && ({{(PW - 1){1'b0}}, need} <= free_slots);
    drop = (need != '0) && !push;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(need);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // NOTE: record storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) < need) mem[wptr_q[AW-1:0] + AW'(i)] <= slot[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_q    <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (counts_instr) icnt_q <= icnt_inc;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (drop) overflow <= 1'b1;
      if (run && mem_rd && mem_wrt) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // A halt leaves RUN even when its record was dropped; DONE holds until reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (halt)  state_d = DRAIN;
      DRAIN:   if (empty) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  assign done = (state_q == DONE);

  // First-word-fall-through head; fields read as zero while nothing is presented.
  assign head        = mem[rptr_q[AW-1:0]];
  assign tr.tr_valid = !empty;
  assign tr.tr_kind  = empty ? 2'b00 : head.kind;
  assign tr.tr_a     = empty ? 16'h0 : head.a;
  assign tr.tr_b     = empty ? 16'h0 : head.b;
`ifdef TRACE_CYCLE_STAMP_EN
  assign tr.tr_cycle = empty ? 16'h0 : head.stamp;
`else
  assign tr.tr_cycle = 16'h0;
`endif

endmodule

// File: tb/tb_retire_trace_tx.sv
// Directed bench for retire_trace_tx: a reference model pushes expected records into a
// scoreboard queue as retire stimulus is driven and pops/compares them on each handshake.
module tb_retire_trace_tx;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_wrt = 1'b0;
  logic [2:0]  wr_reg = '0;
  logic [15:0] wr_data = '0;
  logic        mem_rd = 1'b0;
  logic        mem_wrt = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_data_in = '0;
  logic [15:0] mem_data_out = '0;
  logic        halt = 1'b0;
  logic [7:0]  drop_cnt;
  logic        overflow, proto_err, done;

  retire_trace_if tr_if ();

  retire_trace_tx #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_wrt      (reg_wrt),
    .wr_reg       (wr_reg),
    .wr_data      (wr_data),
    .mem_rd       (mem_rd),
    .mem_wrt      (mem_wrt),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .halt         (halt),
    .tr           (tr_if.master),
    .drop_cnt     (drop_cnt),
    .overflow     (overflow),
    .proto_err    (proto_err),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] cyc;
  } rec_t;

  rec_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_state = 0;          // 0 RUN, 1 DRAIN, 2 DONE
  logic [15:0] m_icnt  = '0;
  logic [7:0]  m_drop  = '0;
  logic        m_ovf   = 1'b0;
  logic        m_proto = 1'b0;
  logic [15:0] tb_cyc  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic rec_t mk(input logic [1:0] kind, input logic [15:0] a, input logic [15:0] b);
    rec_t r;
    r.kind = kind;
    r.a    = a;
    r.b    = b;
`ifdef TRACE_CYCLE_STAMP_EN
    r.cyc  = tb_cyc;
`else
    r.cyc  = '0;
`endif
    return r;
  endfunction

  // One clock: compare the presented head, advance the model, clock, compare status.
  task automatic step();
    rec_t recs[$];
    int   size0;
    size0 = exp_q.size();
    check("tr_valid", tr_if.tr_valid, size0 != 0);
    if (size0 != 0) begin
      check("tr_kind",  tr_if.tr_kind,  exp_q[0].kind);
      check("tr_a",     tr_if.tr_a,     exp_q[0].a);
      check("tr_b",     tr_if.tr_b,     exp_q[0].b);
      check("tr_cycle", tr_if.tr_cycle, exp_q[0].cyc);
      if (tr_if.tr_ready) void'(exp_q.pop_front());
    end
    if (m_state == 0) begin
      if (mem_rd && mem_wrt) m_proto = 1'b1;
      if (reg_wrt || mem_wrt || halt) m_icnt = m_icnt + 16'd1;
      if (reg_wrt) recs.push_back(mk(2'b00, {13'b0, wr_reg}, wr_data));
      if (mem_wrt)     recs.push_back(mk(2'b10, mem_addr, mem_data_in));
      else if (mem_rd) recs.push_back(mk(2'b01, mem_addr, mem_data_out));
      if (halt) recs.push_back(mk(2'b11, 16'h0, m_icnt));
      if (recs.size() > 0) begin
        if (recs.size() <= DEPTH - exp_q.size()) begin
          foreach (recs[i]) exp_q.push_back(recs[i]);
        end else begin
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
          m_ovf = 1'b1;
        end
      end
      if (halt) m_state = 1;
    end else if (m_state == 1 && size0 == 0) begin
      m_state = 2;
    end
    @(posedge clk);
    tb_cyc = tb_cyc + 16'd1;
    @(negedge clk);
    check("drop_cnt",  drop_cnt,  m_drop);
    check("overflow",  overflow,  m_ovf);
    check("proto_err", proto_err, m_proto);
    check("done",      done,      m_state == 2);
  endtask

  task automatic clear_inputs();
    reg_wrt = 1'b0; wr_reg = '0; wr_data = '0;
    mem_rd = 1'b0; mem_wrt = 1'b0; mem_addr = '0;
    mem_data_in = '0; mem_data_out = '0; halt = 1'b0;
  endtask

  task automatic retire(input logic rw, input logic [2:0] r, input logic [15:0] d,
                        input logic mr, input logic mw, input logic [15:0] ad,
                        input logic [15:0] di, input logic [15:0] dout, input logic h);
    reg_wrt = rw; wr_reg = r; wr_data = d;
    mem_rd = mr; mem_wrt = mw; mem_addr = ad;
    mem_data_in = di; mem_data_out = dout; halt = h;
    step();
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asserted at a falling edge; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_tr_valid",  tr_if.tr_valid, 1'b0);
    check("rst_tr_kind",   tr_if.tr_kind,  2'b00);
    check("rst_tr_a",      tr_if.tr_a,     16'h0);
    check("rst_tr_b",      tr_if.tr_b,     16'h0);
    check("rst_tr_cycle",  tr_if.tr_cycle, 16'h0);
    check("rst_drop_cnt",  drop_cnt,       8'h0);
    check("rst_overflow",  overflow,       1'b0);
    check("rst_proto_err", proto_err,      1'b0);
    check("rst_done",      done,           1'b0);
    exp_q.delete();
    m_state = 0; m_icnt = '0; m_drop = '0; m_ovf = 1'b0; m_proto = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    tb_cyc = '0;
  endtask

  initial begin
    tr_if.tr_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Single REG record, then REG+LOAD from one cycle on consecutive pops.
    retire(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    idle(2);
    retire(1'b1, 3'd5, 16'hBEEF, 1'b1, 1'b0, 16'h0040, 16'h0, 16'hBEEF, 1'b0);
    idle(3);

    // Load and store together: one STORE record and a sticky protocol error.
    retire(1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 16'h0080, 16'h5555, 16'hAAAA, 1'b0);
    idle(2);
    retire(1'b1, 3'd7, 16'h0F0F, 1'b0, 1'b1, 16'h1000, 16'h2222, 16'h0, 1'b0);
    retire(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 16'h2000, 16'h0, 16'h3333, 1'b0);
    idle(3);

    // Stall the consumer: fill 7, drop a two-record cycle, fill the 8th, drop again.
    tr_if.tr_ready = 1'b0;
    for (int i = 0; i < 7; i++) retire(1'b1, 3'(i), 16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    retire(1'b1, 3'd2, 16'hDEAD, 1'b0, 1'b1, 16'h3000, 16'hCAFE, 16'h0, 1'b0);
    check("drop_after_first_overflow", drop_cnt, 8'd1);
    retire(1'b1, 3'd1, 16'h0808, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    retire(1'b1, 3'd1, 16'h0909, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    // Full FIFO, but a same-cycle pop leaves room for one record.
    tr_if.tr_ready = 1'b1;
    retire(1'b1, 3'd4, 16'h4444, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    tr_if.tr_ready = 1'b0;
    for (int i = 0; i < 258; i++) retire(1'b1, 3'd0, 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    check("drop_cnt_saturated", drop_cnt, 8'hFF);
    tr_if.tr_ready = 1'b1;
    idle(12);

    // Reset while records are queued discards them.
    tr_if.tr_ready = 1'b0;
    for (int i = 0; i < 4; i++) retire(1'b1, 3'd6, 16'hA000 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    do_reset();
    tr_if.tr_ready = 1'b1;
    idle(2);
    retire(1'b1, 3'd6, 16'h6666, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);

    // Counting cycles (a load alone does not count), then REG+STORE+HALT in one cycle.
    retire(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 16'h0100, 16'h0, 16'h1111, 1'b0);
    retire(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'h0200, 16'h2222, 16'h0, 1'b0);
    retire(1'b1, 3'd1, 16'h3333, 1'b1, 1'b0, 16'h0300, 16'h0, 16'h4444, 1'b0);
    retire(1'b1, 3'd2, 16'h5555, 1'b0, 1'b1, 16'h0400, 16'h6666, 16'h0, 1'b0);
    retire(1'b1, 3'd3, 16'h7777, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    retire(1'b1, 3'd2, 16'h7777, 1'b0, 1'b1, 16'h5000, 16'h8888, 16'h0, 1'b1);
    check("halt_instr_count", m_icnt, 16'd6);

    // Retire inputs stay active while draining and must be ignored.
    reg_wrt = 1'b1; wr_reg = 3'd7; wr_data = 16'hFFFF; mem_wrt = 1'b1; halt = 1'b1;
    for (int i = 0; i < 30 && m_state != 2; i++) step();
    check("done_after_drain", done, 1'b1);
    idle(3);
    clear_inputs();

    // A dropped HALT still ends the run.
    do_reset();
    tr_if.tr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) retire(1'b1, 3'd5, 16'hC000 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    retire(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    tr_if.tr_ready = 1'b1;
    for (int i = 0; i < 30 && m_state != 2; i++) step();
    check("done_after_dropped_halt", done, 1'b1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
